// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types, instruction-word layout and default lengths for
// the core sequencer. Optional feature macro: CORE_SEQ_ACC_EN (adds S_ACC).
package core_seq_pkg;

   localparam int unsigned INST_W = 34;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned KIJ_W  = 4;
   localparam int unsigned CNT_W  = 16;

   // Default geometry of one convolution sweep
   localparam int unsigned        DEF_COL      = 8;
   localparam int unsigned        DEF_LEN_KIJ  = 9;
   localparam int unsigned        DEF_LEN_NIJ  = 36;
   localparam int unsigned        DEF_LEN_ONIJ = 16;
   localparam int unsigned        DEF_GAP      = 10;
   localparam logic [ADDR_W-1:0]  DEF_W_BASE   = 11'h400;

   // Instruction word bit positions
   localparam int unsigned B_ACC      = 33;
   localparam int unsigned B_CEN_P    = 32;
   localparam int unsigned B_WEN_P    = 31;
   localparam int unsigned B_A_P      = 20;
   localparam int unsigned B_CEN_X    = 19;
   localparam int unsigned B_WEN_X    = 18;
   localparam int unsigned B_A_X      = 7;
   localparam int unsigned B_OFIFO_RD = 6;
   localparam int unsigned B_IFIFO_WR = 5;
   localparam int unsigned B_IFIFO_RD = 4;
   localparam int unsigned B_L0_RD    = 3;
   localparam int unsigned B_L0_WR    = 2;
   localparam int unsigned B_EXECUTE  = 1;
   localparam int unsigned B_LOAD     = 0;

   // Both memories disabled, everything else quiet
   localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_L0,
      S_LOAD,
      S_GAP,
      S_X_L0,
      S_EXEC,
      S_OFRD,
      S_NEXT,
`ifdef CORE_SEQ_ACC_EN
      S_ACC,
`endif
      S_DONE
   } state_t;

   // xmem->L0 fill: cycle 0 primes the read, cycles 1..len write L0,
   // the read enable drops on the final cycle.
   function automatic logic [INST_W-1:0] fill_word(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  c,
                                                   input logic [CNT_W-1:0]  len);
      logic [INST_W-1:0] w;
      w = IDLE_WORD;
      if (c != CNT_W'(0)) w[B_L0_WR] = 1'b1;
      if (c < len) begin
         w[B_CEN_X]            = 1'b0;
         w[B_A_X +: ADDR_W]    = base + ADDR_W'(c);
      end
      return w;
   endfunction

   // L0 drain into the array: weight load or execute
   function automatic logic [INST_W-1:0] l0_rd_word(input logic exe);
      logic [INST_W-1:0] w;
      w = IDLE_WORD;
      w[B_L0_RD] = 1'b1;
      if (exe) w[B_EXECUTE] = 1'b1;
      else     w[B_LOAD]    = 1'b1;
      return w;
   endfunction

   // OFIFO pop written straight into pmem
   function automatic logic [INST_W-1:0] ofrd_word(input logic [ADDR_W-1:0] addr);
      logic [INST_W-1:0] w;
      w = IDLE_WORD;
      w[B_OFIFO_RD]       = 1'b1;
      w[B_CEN_P]          = 1'b0;
      w[B_WEN_P]          = 1'b0;
      w[B_A_P +: ADDR_W]  = addr;
      return w;
   endfunction

`ifdef CORE_SEQ_ACC_EN
   // Accumulation pass: read psum k of pixel o; acc trails each read by one cycle
   function automatic logic [INST_W-1:0] acc_word(input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] o,
                                                  input int unsigned      len_kij,
                                                  input int unsigned      len_onij);
      logic [INST_W-1:0] w;
      w = IDLE_WORD;
      if (32'(c) < len_kij) begin
         w[B_CEN_P]         = 1'b0;
         w[B_A_P +: ADDR_W] = ADDR_W'(32'(c) * len_onij + 32'(o));
      end
      if (c != CNT_W'(0) && 32'(c) <= len_kij) w[B_ACC] = 1'b1;
      return w;
   endfunction
`endif

endpackage

// File: rtl/core_seq.sv
// core_seq: per-kij instruction sequencer for the systolic core.
// Walks W_L0 -> LOAD -> GAP -> X_L0 -> EXEC -> OFRD -> NEXT for every kernel
// index, registering one 34-bit instruction word per cycle.
// Optional feature macro: CORE_SEQ_ACC_EN (psum accumulation pass before DONE).
module core_seq
   import core_seq_pkg::*;
#(
   parameter int unsigned       COL      = DEF_COL,
   parameter int unsigned       LEN_KIJ  = DEF_LEN_KIJ,
   parameter int unsigned       LEN_NIJ  = DEF_LEN_NIJ,
   parameter int unsigned       LEN_ONIJ = DEF_LEN_ONIJ,
   parameter int unsigned       GAP      = DEF_GAP,
   parameter logic [ADDR_W-1:0] W_BASE   = DEF_W_BASE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done,
   output logic [KIJ_W-1:0]  kij
);

   localparam logic [CNT_W-1:0] C_COL       = CNT_W'(COL);
   localparam logic [CNT_W-1:0] C_KIJ_LAST  = CNT_W'(LEN_KIJ - 1);
   localparam logic [CNT_W-1:0] C_GAP       = CNT_W'(GAP);
   localparam logic [CNT_W-1:0] C_NIJ       = CNT_W'(LEN_NIJ);
   localparam logic [CNT_W-1:0] C_ONIJ      = CNT_W'(LEN_ONIJ);
   localparam logic [CNT_W-1:0] C_ONIJ_LAST = CNT_W'(LEN_ONIJ - 1);
   localparam logic [KIJ_W-1:0] KIJ_LAST    = KIJ_W'(LEN_KIJ - 1);
`ifdef CORE_SEQ_ACC_EN
   localparam logic [CNT_W-1:0] C_ACC_LAST  = CNT_W'(LEN_KIJ + 1);
`endif

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  rd_n;
`ifdef CORE_SEQ_ACC_EN
   logic [CNT_W-1:0]  acc_o;
`endif

   logic [ADDR_W-1:0] w_base_cur;
   logic [ADDR_W-1:0] w_base_nxt;
   logic [ADDR_W-1:0] p_base;

   // Kernel/psum base addresses for the current and following kij
   assign w_base_cur = ADDR_W'(32'(W_BASE) + 32'(kij) * COL);
   assign w_base_nxt = ADDR_W'(32'(W_BASE) + (32'(kij) + 32'd1) * COL);
   assign p_base     = ADDR_W'(32'(kij) * LEN_ONIJ);

   // Sequencer: each branch picks the next state and the word for that next cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         rd_n  <= '0;
         kij   <= '0;
         inst  <= IDLE_WORD;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef CORE_SEQ_ACC_EN
         acc_o <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               inst <= IDLE_WORD;
               if (start) begin
                  state <= S_W_L0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  inst  <= fill_word(W_BASE, CNT_W'(0), C_COL);
               end
            end

            S_W_L0: begin
               if (cnt == C_COL) begin
                  state <= S_LOAD;
                  cnt   <= '0;
                  inst  <= l0_rd_word(1'b0);
               end else begin
                  cnt  <= cnt + 1'b1;
                  inst <= fill_word(w_base_cur, cnt + 1'b1, C_COL);
               end
            end

            S_LOAD: begin
               if (cnt == C_KIJ_LAST) begin
                  state <= S_GAP;
                  cnt   <= '0;
                  inst  <= IDLE_WORD;
               end else begin
                  cnt  <= cnt + 1'b1;
                  inst <= l0_rd_word(1'b0);
               end
            end

            S_GAP: begin
               if (cnt == C_GAP) begin
                  state <= S_X_L0;
                  cnt   <= '0;
                  inst  <= fill_word(ADDR_W'(0), CNT_W'(0), C_NIJ);
               end else begin
                  cnt  <= cnt + 1'b1;
                  inst <= IDLE_WORD;
               end
            end

            S_X_L0: begin
               if (cnt == C_NIJ) begin
                  state <= S_EXEC;
                  cnt   <= '0;
                  inst  <= l0_rd_word(1'b1);
               end else begin
                  cnt  <= cnt + 1'b1;
                  inst <= fill_word(ADDR_W'(0), cnt + 1'b1, C_NIJ);
               end
            end

            S_EXEC: begin
               if (cnt == C_ONIJ_LAST) begin
                  state <= S_OFRD;
                  cnt   <= '0;
                  if (ofifo_valid) begin
                     inst <= ofrd_word(p_base);
                     rd_n <= CNT_W'(1);
                  end else begin
                     inst <= IDLE_WORD;
                     rd_n <= '0;
                  end
               end else begin
                  cnt  <= cnt + 1'b1;
                  inst <= l0_rd_word(1'b1);
               end
            end

            // Pop only while the OFIFO reports data; no timeout on a stall
            S_OFRD: begin
               if (rd_n == C_ONIJ) begin
                  state <= S_NEXT;
                  inst  <= IDLE_WORD;
               end else if (ofifo_valid) begin
                  inst <= ofrd_word(p_base + ADDR_W'(rd_n));
                  rd_n <= rd_n + 1'b1;
               end else begin
                  inst <= IDLE_WORD;
               end
            end

            S_NEXT: begin
               cnt <= '0;
               if (kij < KIJ_LAST) begin
                  state <= S_W_L0;
                  kij   <= kij + 1'b1;
                  inst  <= fill_word(w_base_nxt, CNT_W'(0), C_COL);
               end else begin
`ifdef CORE_SEQ_ACC_EN
                  state <= S_ACC;
                  acc_o <= '0;
                  inst  <= acc_word(CNT_W'(0), CNT_W'(0), LEN_KIJ, LEN_ONIJ);
`else
                  state <= S_DONE;
                  done  <= 1'b1;
                  kij   <= '0;
                  inst  <= IDLE_WORD;
`endif
               end
            end

`ifdef CORE_SEQ_ACC_EN
            // Per pixel: LEN_KIJ reads, one trailing acc cycle, one idle cycle
            S_ACC: begin
               if (cnt == C_ACC_LAST) begin
                  cnt <= '0;
                  if (acc_o == C_ONIJ_LAST) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     kij   <= '0;
                     inst  <= IDLE_WORD;
                  end else begin
                     acc_o <= acc_o + 1'b1;
                     inst  <= acc_word(CNT_W'(0), acc_o + 1'b1, LEN_KIJ, LEN_ONIJ);
                  end
               end else begin
                  cnt  <= cnt + 1'b1;
                  inst <= acc_word(cnt + 1'b1, acc_o, LEN_KIJ, LEN_ONIJ);
               end
            end
`endif

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
               rd_n  <= '0;
               inst  <= IDLE_WORD;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
               rd_n  <= '0;
               kij   <= '0;
               inst  <= IDLE_WORD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: directed-vector bench for core_seq (default parameters).
// Build with +define+CORE_SEQ_ACC_EN to cover the accumulation pass.
`timescale 1ns/1ps
module tb_core_seq;
   import core_seq_pkg::*;

   localparam int LIMIT = 1200;
   localparam logic [33:0] IDLE_W   = 34'h1_800C_0000;
   localparam logic [33:0] W0_PRIME = 34'h1_8006_0000;  // A_xmem=0x400, CEN_xmem=0
   localparam logic [33:0] LOAD_W   = 34'h1_800C_0009;
   localparam logic [33:0] EXEC_W   = 34'h1_800C_000A;
   localparam logic [33:0] X0_PRIME = 34'h1_8004_0000;
   localparam logic [33:0] X35_W    = 34'h1_8004_1184;  // A_xmem=35, l0_wr
   localparam logic [33:0] X_CLOSE  = 34'h1_800C_0004;
   localparam logic [33:0] OFRD0_W  = 34'h0_000C_0040;
`ifdef CORE_SEQ_ACC_EN
   localparam int EXP_DONE = 1067;   // 891 + 16*(9+2)
   localparam int EXP_ACC  = 144;
`else
   localparam int EXP_DONE = 891;    // done shows in the 892nd cycle from the start edge
   localparam int EXP_ACC  = 0;
`endif

   logic        clk = 1'b0;
   logic        reset, start, ofifo_valid;
   logic [33:0] inst;
   logic        busy, done;
   logic [3:0]  kij;

   int vec = 0;
   int err = 0;

   logic [33:0] tr_inst [0:LIMIT-1];
   logic        tr_busy [0:LIMIT-1];
   logic        tr_done [0:LIMIT-1];
   logic [3:0]  tr_kij  [0:LIMIT-1];
   int          n_tr;

   core_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .kij         (kij)
   );

   always #5 clk = ~clk;

   // Pulse start, then record one sample per cycle (cycle 0 = first cycle after the start edge)
   task automatic capture(input int stall_at, input int stall_len, input int start_at,
                          input int reset_at, output int done_t);
      done_t      = -1;
      n_tr        = 0;
      ofifo_valid = 1'b1;
      reset       = 1'b1;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < LIMIT; t++) begin
         tr_inst[t] = inst;
         tr_busy[t] = busy;
         tr_done[t] = done;
         tr_kij[t]  = kij;
         n_tr = t + 1;
         if (done === 1'b1 && done_t < 0) done_t = t;
         if (done_t >= 0 && t >= done_t + 20) break;
         ofifo_valid = !(t >= stall_at && t < stall_at + stall_len);
         start       = (t == start_at);
         reset       = !(t == reset_at);
         @(posedge clk); #1;
      end
      start       = 1'b0;
      reset       = 1'b1;
      ofifo_valid = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec++; if (inst !== IDLE_W) begin err++; $display("FAIL reset_inst got %h want %h", inst, IDLE_W); end
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
      vec++; if (done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", done); end
      vec++; if (kij !== 4'd0) begin err++; $display("FAIL reset_kij got %0d want 0", kij); end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vec++; if (inst !== IDLE_W || busy !== 1'b0) begin
         err++; $display("FAIL idle_hold inst %h busy %b want %h 0", inst, busy, IDLE_W);
      end
   endtask

   task automatic test_full_sweep();
      int dt, nrd, bad_rd, busy_lo, n_l0wr, n_load, n_exec, n_acc;
      capture(LIMIT, 0, -1, -1, dt);
      vec++; if (dt !== EXP_DONE) begin err++; $display("FAIL sweep_done_cycle got %0d want %0d", dt, EXP_DONE); end
      for (int k = 0; k < 9; k++) begin
         vec++; if (tr_kij[99*k] !== 4'(k)) begin
            err++; $display("FAIL kij_at_%0d got %0d want %0d", 99*k, tr_kij[99*k], k);
         end
      end
      vec++; if (tr_kij[EXP_DONE] !== 4'd0) begin err++; $display("FAIL kij_at_done got %0d want 0", tr_kij[EXP_DONE]); end
      vec++; if (tr_inst[0]  !== W0_PRIME) begin err++; $display("FAIL w_l0_first got %h want %h", tr_inst[0], W0_PRIME); end
      vec++; if (tr_inst[9]  !== LOAD_W)   begin err++; $display("FAIL load_word got %h want %h", tr_inst[9], LOAD_W); end
      vec++; if (tr_inst[20] !== IDLE_W)   begin err++; $display("FAIL gap_word got %h want %h", tr_inst[20], IDLE_W); end
      vec++; if (tr_inst[29] !== X0_PRIME) begin err++; $display("FAIL x_l0_first got %h want %h", tr_inst[29], X0_PRIME); end
      vec++; if (tr_inst[64] !== X35_W)    begin err++; $display("FAIL x_l0_last_rd got %h want %h", tr_inst[64], X35_W); end
      vec++; if (tr_inst[65] !== X_CLOSE)  begin err++; $display("FAIL x_l0_close got %h want %h", tr_inst[65], X_CLOSE); end
      vec++; if (tr_inst[66] !== EXEC_W)   begin err++; $display("FAIL exec_word got %h want %h", tr_inst[66], EXEC_W); end
      vec++; if (tr_inst[82] !== OFRD0_W)  begin err++; $display("FAIL ofrd_first got %h want %h", tr_inst[82], OFRD0_W); end
      vec++; if (tr_inst[98] !== IDLE_W)   begin err++; $display("FAIL next_word got %h want %h", tr_inst[98], IDLE_W); end
      nrd = 0; bad_rd = 0; busy_lo = 0; n_l0wr = 0; n_load = 0; n_exec = 0; n_acc = 0;
      for (int t = 0; t <= EXP_DONE; t++) begin
         if (tr_busy[t] !== 1'b1) busy_lo++;
         if (tr_inst[t][2] === 1'b1) n_l0wr++;
         if (tr_inst[t][0] === 1'b1) n_load++;
         if (tr_inst[t][1] === 1'b1) n_exec++;
         if (tr_inst[t][33] === 1'b1) n_acc++;
         if (tr_inst[t][6] === 1'b1) begin
            if (tr_inst[t][30:20] !== 11'(nrd) || tr_inst[t][32:31] !== 2'b00) bad_rd++;
            nrd++;
         end
      end
      vec++; if (busy_lo !== 0)   begin err++; $display("FAIL busy_low_cycles got %0d want 0", busy_lo); end
      vec++; if (nrd !== 144)     begin err++; $display("FAIL ofifo_reads got %0d want 144", nrd); end
      vec++; if (bad_rd !== 0)    begin err++; $display("FAIL pmem_write_seq got %0d bad want 0", bad_rd); end
      vec++; if (n_l0wr !== 396)  begin err++; $display("FAIL l0_wr_cycles got %0d want 396", n_l0wr); end
      vec++; if (n_load !== 81)   begin err++; $display("FAIL load_cycles got %0d want 81", n_load); end
      vec++; if (n_exec !== 144)  begin err++; $display("FAIL exec_cycles got %0d want 144", n_exec); end
      vec++; if (n_acc !== EXP_ACC) begin err++; $display("FAIL acc_cycles got %0d want %0d", n_acc, EXP_ACC); end
      vec++; if (tr_done[EXP_DONE+1] !== 1'b0 || tr_busy[EXP_DONE+1] !== 1'b0) begin
         err++; $display("FAIL after_done done %b busy %b want 0 0", tr_done[EXP_DONE+1], tr_busy[EXP_DONE+1]);
      end
   endtask

   // Uses the trace left by test_full_sweep
   task automatic test_w_l0_kij2();
      int bad_a, n_wr;
      bad_a = 0; n_wr = 0;
      for (int i = 0; i < 8; i++) begin
         if (tr_inst[198+i][17:7] !== 11'h410 + 11'(i) || tr_inst[198+i][19] !== 1'b0) bad_a++;
      end
      for (int i = 0; i < 9; i++) if (tr_inst[198+i][2] === 1'b1) n_wr++;
      vec++; if (bad_a !== 0) begin err++; $display("FAIL kij2_xmem_addr got %0d bad want 0", bad_a); end
      vec++; if (tr_inst[206][19] !== 1'b1) begin err++; $display("FAIL kij2_cen_close got %b want 1", tr_inst[206][19]); end
      vec++; if (n_wr !== 8) begin err++; $display("FAIL kij2_l0_wr got %0d want 8", n_wr); end
      vec++; if (tr_inst[198][2] !== 1'b0) begin err++; $display("FAIL kij2_prime_wr got %b want 0", tr_inst[198][2]); end
   endtask

   task automatic test_ofrd_stall();
      int dt, nrd, bad_rd, gap_rd;
      capture(185, 5, -1, -1, dt);
      vec++; if (dt !== EXP_DONE + 5) begin err++; $display("FAIL stall_done_cycle got %0d want %0d", dt, EXP_DONE + 5); end
      nrd = 0; bad_rd = 0; gap_rd = 0;
      for (int t = 0; t < EXP_DONE + 5; t++) begin
         if (tr_inst[t][6] === 1'b1) begin
            if (tr_inst[t][30:20] !== 11'(nrd)) bad_rd++;
            nrd++;
         end
      end
      for (int t = 186; t <= 190; t++) if (tr_inst[t][6] !== 1'b0) gap_rd++;
      vec++; if (nrd !== 144)   begin err++; $display("FAIL stall_reads got %0d want 144", nrd); end
      vec++; if (bad_rd !== 0)  begin err++; $display("FAIL stall_pmem_seq got %0d bad want 0", bad_rd); end
      vec++; if (gap_rd !== 0)  begin err++; $display("FAIL stall_rd_while_empty got %0d want 0", gap_rd); end
      vec++; if (tr_inst[185][30:20] !== 11'd20 || tr_inst[185][6] !== 1'b1) begin
         err++; $display("FAIL stall_last_before got %h want read of 20", tr_inst[185]);
      end
      vec++; if (tr_inst[191][30:20] !== 11'd21 || tr_inst[191][6] !== 1'b1) begin
         err++; $display("FAIL stall_resume got %h want read of 21", tr_inst[191]);
      end
   endtask

   task automatic test_reset_mid();
      int dt, busy_hi;
      capture(LIMIT, 0, -1, 470, dt);
      vec++; if (tr_kij[470] !== 4'd4 || tr_inst[470] !== EXEC_W) begin
         err++; $display("FAIL pre_reset kij %0d inst %h want 4 %h", tr_kij[470], tr_inst[470], EXEC_W);
      end
      vec++; if (tr_inst[471] !== IDLE_W) begin err++; $display("FAIL mid_reset_inst got %h want %h", tr_inst[471], IDLE_W); end
      vec++; if (tr_busy[471] !== 1'b0 || tr_kij[471] !== 4'd0) begin
         err++; $display("FAIL mid_reset_state busy %b kij %0d want 0 0", tr_busy[471], tr_kij[471]);
      end
      busy_hi = 0;
      for (int t = 471; t < n_tr; t++) if (tr_busy[t] !== 1'b0) busy_hi++;
      vec++; if (busy_hi !== 0 || dt !== -1) begin
         err++; $display("FAIL no_resume busy_cycles %0d done_at %0d want 0 -1", busy_hi, dt);
      end
      capture(LIMIT, 0, -1, -1, dt);
      vec++; if (tr_inst[0] !== W0_PRIME || tr_kij[0] !== 4'd0) begin
         err++; $display("FAIL restart_first inst %h kij %0d want %h 0", tr_inst[0], tr_kij[0], W0_PRIME);
      end
      vec++; if (dt !== EXP_DONE) begin err++; $display("FAIL restart_done_cycle got %0d want %0d", dt, EXP_DONE); end
   endtask

   task automatic test_start_ignored();
      int dt, n_done, busy_hi;
      capture(LIMIT, 0, 20, -1, dt);
      vec++; if (tr_inst[21] !== IDLE_W) begin err++; $display("FAIL gap_start_inst got %h want %h", tr_inst[21], IDLE_W); end
      vec++; if (dt !== EXP_DONE) begin err++; $display("FAIL gap_start_done_cycle got %0d want %0d", dt, EXP_DONE); end
      n_done = 0; busy_hi = 0;
      for (int t = 0; t < n_tr; t++) if (tr_done[t] === 1'b1) n_done++;
      for (int t = EXP_DONE + 1; t < n_tr; t++) if (tr_busy[t] !== 1'b0) busy_hi++;
      vec++; if (n_done !== 1)  begin err++; $display("FAIL done_pulses got %0d want 1", n_done); end
      vec++; if (busy_hi !== 0) begin err++; $display("FAIL second_sweep busy_cycles got %0d want 0", busy_hi); end
   endtask

`ifdef CORE_SEQ_ACC_EN
   task automatic test_acc();
      int dt, bad_a, n_acc;
      capture(LIMIT, 0, -1, -1, dt);
      vec++; if (dt !== EXP_DONE) begin err++; $display("FAIL acc_done_cycle got %0d want %0d", dt, EXP_DONE); end
      bad_a = 0; n_acc = 0;
      for (int c = 0; c < 9; c++) begin
         if (tr_inst[924+c][30:20] !== 11'(3 + 16*c) || tr_inst[924+c][32:31] !== 2'b01) bad_a++;
      end
      for (int t = 925; t <= 933; t++) if (tr_inst[t][33] === 1'b1) n_acc++;
      vec++; if (bad_a !== 0) begin err++; $display("FAIL acc_o3_reads got %0d bad want 0", bad_a); end
      vec++; if (n_acc !== 9) begin err++; $display("FAIL acc_o3_acc got %0d want 9", n_acc); end
      vec++; if (tr_inst[924][33] !== 1'b0 || tr_inst[934][33] !== 1'b0) begin
         err++; $display("FAIL acc_o3_edges got %b %b want 0 0", tr_inst[924][33], tr_inst[934][33]);
      end
      vec++; if (tr_inst[933][32] !== 1'b1) begin err++; $display("FAIL acc_trail_cen got %b want 1", tr_inst[933][32]); end
   endtask
`endif

   initial begin
      reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
      test_reset();
      test_full_sweep();
      test_w_l0_kij2();
      test_ofrd_stall();
      test_reset_mid();
      test_start_ignored();
`ifdef CORE_SEQ_ACC_EN
      test_acc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
